// File: rtl/apb_pkg.sv
// Shared APB payload types and widths, plus the arbiter state encoding.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
  } apb_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS
  } apb_arb_state_e;

endpackage

// File: rtl/apb_arbiter_rr_picker.sv
// Round-robin search: first set request at or above ptr, wrapping around.
module rr_picker #(
  parameter  int unsigned CPU_NB = 4,
  localparam int unsigned IDX_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
  input  logic [CPU_NB-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < CPU_NB; k++) begin
      int unsigned j;
      j = (32'(ptr) + k) % CPU_NB;
      if (!found && req[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB subordinate among CPU_NB APB managers,
// one downstream SETUP/ACCESS transfer at a time.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter  int unsigned CPU_NB = 4,
  localparam int unsigned IDX_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  apb_req_t           i_apb_m_req     [CPU_NB],
  input  logic [CPU_NB-1:0]  i_apb_m_psel,
  input  logic [CPU_NB-1:0]  i_apb_m_penable,
  output apb_resp_t          o_apb_m_resp    [CPU_NB],
  output logic [CPU_NB-1:0]  o_apb_m_pready,
  output apb_req_t           o_apb_s_req,
  output logic               o_apb_s_psel,
  output logic               o_apb_s_penable,
  input  apb_resp_t          i_apb_s_resp,
  input  logic               i_apb_s_pready,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_busy
);

  apb_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic              done;
  logic [IDX_W-1:0]  next_ptr;
  logic [CPU_NB-1:0] pick_req;
  logic [IDX_W-1:0]  pick_ptr;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  // On completion the finishing manager is masked out and the search restarts after it.
  assign done     = (state_q == ARB_ACCESS) && i_apb_s_pready;
  assign next_ptr = IDX_W'((32'(grant_q) + 32'd1) % CPU_NB);
  assign pick_req = i_apb_m_psel & ~(done ? (CPU_NB'(1) << grant_q) : '0);
  assign pick_ptr = done ? next_ptr : ptr_q;

  rr_picker #(.CPU_NB(CPU_NB)) u_picker (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    o_busy          = 1'b0;
    o_apb_s_psel    = 1'b0;
    o_apb_s_penable = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        o_busy       = 1'b1;
        o_apb_s_psel = 1'b1;
        state_d      = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        o_busy          = 1'b1;
        o_apb_s_psel    = 1'b1;
        o_apb_s_penable = 1'b1;
        if (i_apb_s_pready) begin
          ptr_d = next_ptr;
          if (pick_found) begin
            grant_d = pick_idx;
            state_d = ARB_SETUP;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Response and pready reach only the granted manager; the rest sit in wait states.
  always_comb begin
    o_apb_s_req = (state_q != ARB_IDLE) ? i_apb_m_req[grant_q] : '0;
    for (int i = 0; i < int'(CPU_NB); i++) begin
      o_apb_m_resp[i]   = '0;
      o_apb_m_pready[i] = 1'b0;
      if (state_q == ARB_ACCESS && grant_q == IDX_W'(i)) begin
        o_apb_m_resp[i]   = i_apb_s_resp;
        o_apb_m_pready[i] = i_apb_s_pready && i_apb_m_psel[i] && i_apb_m_penable[i];
      end
    end
  end

  assign o_grant_idx = grant_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: a 4-manager instance plus a 1-manager instance
// backed by a small memory.
module tb_apb_arbiter;
  import apb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_req_t   m_req [4];
  logic [3:0] m_psel, m_pen, m_pready;
  apb_resp_t  m_resp [4];
  apb_req_t   s_req;
  logic       s_psel, s_pen, s_pready, s_pready_nx;
  apb_resp_t  s_resp;
  logic [1:0] grant;
  logic       busy;

  apb_arbiter #(.CPU_NB(4)) dut (
    .clk(clk), .rst(rst),
    .i_apb_m_req(m_req), .i_apb_m_psel(m_psel), .i_apb_m_penable(m_pen),
    .o_apb_m_resp(m_resp), .o_apb_m_pready(m_pready),
    .o_apb_s_req(s_req), .o_apb_s_psel(s_psel), .o_apb_s_penable(s_pen),
    .i_apb_s_resp(s_resp), .i_apb_s_pready(s_pready),
    .o_grant_idx(grant), .o_busy(busy)
  );

  apb_req_t   r1_req [1];
  logic [0:0] r1_psel, r1_pen, r1_pready, g1;
  apb_resp_t  r1_resp [1];
  apb_req_t   s1_req;
  logic       s1_psel, s1_pen, b1;
  apb_resp_t  s1_resp;
  logic [31:0] mem1 [16];

  apb_arbiter #(.CPU_NB(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_apb_m_req(r1_req), .i_apb_m_psel(r1_psel), .i_apb_m_penable(r1_pen),
    .o_apb_m_resp(r1_resp), .o_apb_m_pready(r1_pready),
    .o_apb_s_req(s1_req), .o_apb_s_psel(s1_psel), .o_apb_s_penable(s1_pen),
    .i_apb_s_resp(s1_resp), .i_apb_s_pready(1'b1),
    .o_grant_idx(g1), .o_busy(b1)
  );

  assign s1_resp = {mem1[s1_req.addr[5:2]], 1'b0};
  always @(posedge clk)
    if (s1_psel && s1_pen && s1_req.write) mem1[s1_req.addr[5:2]] <= s1_req.wdata;

  int n_vec = 0;
  int n_err = 0;
  int pend [4];
  int done_cnt [4];
  int since [4];
  int max_wait;
  int total_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle of the manager models: act on what was seen at this negedge,
  // drive new inputs just after the posedge, return at the next negedge.
  task automatic tick();
    logic [3:0] np, ne;
    np = m_psel;
    ne = m_pen;
    for (int i = 0; i < 4; i++) begin
      if (m_psel[i] && m_pen[i] && m_pready[i]) begin
        done_cnt[i]++;
        total_done++;
        pend[i]--;
        for (int j = 0; j < 4; j++) if (j != i) since[j]++;
        if (since[i] > max_wait) max_wait = since[i];
        since[i] = 0;
        np[i] = (pend[i] > 0);
        ne[i] = 1'b0;
      end else if (m_psel[i] && !m_pen[i]) begin
        ne[i] = 1'b1;
      end else if (!m_psel[i] && pend[i] > 0) begin
        np[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_psel   = np;
    m_pen    = ne;
    s_pready = s_pready_nx;
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int c;
    c = 0;
    while ((pend[0] + pend[1] + pend[2] + pend[3] > 0 || busy) && c < bound) begin
      tick();
      c++;
    end
    check_eq(tag, c >= bound, 1'b0);
  endtask

  task automatic xfer1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, inout int bad_grant);
    logic ok;
    ok = 1'b0;
    rdata = '0;
    r1_req[0] = '{addr: addr, write: wr, wdata: wdata};
    r1_psel = 1'b1;
    r1_pen  = 1'b0;
    @(posedge clk);
    #1 r1_pen = 1'b1;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (b1 && g1 != 1'b0) bad_grant++;
      if (r1_pready[0]) begin
        ok = 1'b1;
        rdata = r1_resp[0].rdata;
      end
    end
    check_eq("t6_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
    r1_psel = 1'b0;
    r1_pen  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_psel = '0;
    m_pen  = '0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int order [$];
    int exp2 [5];
    int first_b, last_b, nbusy, acc, base, mx, mn;
    int bad_grant;
    logic [31:0] rd;

    exp2 = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      m_req[i] = '0; pend[i] = 0; done_cnt[i] = 0; since[i] = 0;
    end
    for (int i = 0; i < 16; i++) mem1[i] = '0;
    max_wait = 0;
    s_resp = '0;
    s_pready = 1'b1;
    s_pready_nx = 1'b1;
    r1_req[0] = '0;
    r1_psel = 1'b0;
    r1_pen  = 1'b0;
    m_psel = '0;
    m_pen  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sel_en", {s_psel, s_pen}, 2'b00);
    check_eq("rst_pready", m_pready, 4'b0000);
    check_eq("rst_grant", grant, 2'd0);
    check_eq("rst_sreq", s_req, '0);
    check_eq("rst_resp", |{m_resp[0], m_resp[1], m_resp[2], m_resp[3]}, 1'b0);
    check_eq("rst1_busy", {b1, s1_psel, g1}, 3'b000);
    rst = 1'b0;

    // Test 1: single write from CPU2
    m_req[2] = '{addr: 32'h10, write: 1'b1, wdata: 32'hDEADBEEF};
    pend[2] = 1;
    tick();
    check_eq("t1_c0_psel", s_psel, 1'b0);
    tick();
    check_eq("t1_setup", {s_psel, s_pen}, 2'b10);
    check_eq("t1_grant", grant, 2'd2);
    check_eq("t1_setup_pready", m_pready, 4'b0000);
    tick();
    check_eq("t1_access", {s_psel, s_pen}, 2'b11);
    check_eq("t1_wdata", s_req.wdata, 32'hDEADBEEF);
    check_eq("t1_addr", s_req.addr, 32'h10);
    check_eq("t1_pready", m_pready, 4'b0100);
    tick();
    check_eq("t1_after_pready", m_pready, 4'b0000);
    check_eq("t1_after_busy", busy, 1'b0);

    // Test 2: all four request from reset, CPU0 twice
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_req[i] = '{addr: 32'(i * 4), write: 1'b1, wdata: 32'(i)};
      pend[i] = 1;
    end
    pend[0] = 2;
    first_b = -1; last_b = -1; nbusy = 0;
    for (int c = 0; c < 60 && (pend[0] + pend[1] + pend[2] + pend[3] > 0 || busy); c++) begin
      tick();
      if (s_psel && !s_pen) order.push_back(int'(grant));
      if (busy) begin
        nbusy++;
        if (first_b < 0) first_b = c;
        last_b = c;
      end
    end
    check_eq("t2_count", order.size(), 5);
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("t2_order%0d", k), (k < order.size()) ? order[k] : -1, exp2[k]);
    check_eq("t2_busy_cycles", nbusy, 10);
    check_eq("t2_no_idle_gap", last_b - first_b + 1, 10);

    // Test 3: CPU1 read with 3 wait states, CPU3 waiting behind it
    m_req[1] = '{addr: 32'h20, write: 1'b0, wdata: 32'h0};
    m_req[3] = '{addr: 32'h30, write: 1'b1, wdata: 32'h3333};
    s_resp = '{rdata: 32'h12345678, slverr: 1'b0};
    s_pready_nx = 1'b0;
    pend[1] = 1;
    pend[3] = 1;
    acc = 0;
    for (int c = 0; c < 40 && pend[1] > 0; c++) begin
      tick();
      if (s_pen && grant == 2'd1) begin
        acc++;
        if (acc < 4) begin
          check_eq($sformatf("t3_wait%0d", acc), m_pready, 4'b0000);
        end else begin
          check_eq("t3_pready", m_pready, 4'b0010);
          check_eq("t3_rdata", m_resp[1].rdata, 32'h12345678);
          check_eq("t3_resp3_zero", m_resp[3], '0);
        end
        if (acc == 3) s_pready_nx = 1'b1;
      end
    end
    check_eq("t3_access_cycles", acc, 4);
    run_until_idle("t3_drain", 40);
    check_eq("t3_cpu3_done", pend[3], 0);

    // Test 4: fairness soak, 1000 transfers with random subordinate pready
    base = total_done;
    for (int i = 0; i < 4; i++) begin
      since[i] = 0;
      pend[i] = 100000;
    end
    max_wait = 0;
    begin
      int snap [4];
      for (int i = 0; i < 4; i++) snap[i] = done_cnt[i];
      for (int c = 0; c < 20000 && total_done - base < 1000; c++) begin
        s_pready_nx = 1'($urandom_range(0, 1));
        tick();
      end
      check_eq("t4_total", total_done - base, 1000);
      mx = 0; mn = 1000000;
      for (int i = 0; i < 4; i++) begin
        if (done_cnt[i] - snap[i] > mx) mx = done_cnt[i] - snap[i];
        if (done_cnt[i] - snap[i] < mn) mn = done_cnt[i] - snap[i];
      end
    end
    check_eq("t4_spread_le1", (mx - mn) <= 1, 1'b1);
    check_eq("t4_wait_le3", max_wait <= 3, 1'b1);
    for (int i = 0; i < 4; i++) pend[i] = m_psel[i] ? 1 : 0;
    s_pready_nx = 1'b1;
    run_until_idle("t4_drain", 100);

    // Test 5: reset during CPU1 ACCESS
    s_pready_nx = 1'b0;
    pend[1] = 1;
    acc = 0;
    for (int c = 0; c < 20 && !(s_pen && grant == 2'd1); c++) tick();
    check_eq("t5_in_access", {s_pen, grant}, 3'b101);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_sel_en", {s_psel, s_pen}, 2'b00);
    check_eq("t5_rst_pready", m_pready, 4'b0000);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_sreq", s_req, '0);
    m_req[0] = '{addr: 32'h40, write: 1'b1, wdata: 32'h4};
    pend[0] = 1;
    s_pready_nx = 1'b1;
    tick();
    rst = 1'b0;
    order.delete();
    for (int c = 0; c < 40 && (pend[0] + pend[1] > 0 || busy); c++) begin
      tick();
      if (s_psel && !s_pen) order.push_back(int'(grant));
    end
    check_eq("t5_first", (order.size() > 0) ? order[0] : -1, 0);
    check_eq("t5_second", (order.size() > 1) ? order[1] : -1, 1);

    // Test 6: single-manager instance, write then read back 0x0..0x24
    bad_grant = 0;
    for (int k = 0; k < 10; k++)
      xfer1(1'b1, 32'(k * 4), 32'hA5000000 | 32'(k * 17), rd, bad_grant);
    for (int k = 0; k < 10; k++) begin
      xfer1(1'b0, 32'(k * 4), 32'h0, rd, bad_grant);
      check_eq($sformatf("t6_read%0d", k), rd, 32'hA5000000 | 32'(k * 17));
    end
    check_eq("t6_grant_zero", bad_grant, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
